// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver/transmitter family:
// FSM state codes, parity modes and the parity helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // XOR of the low nbits of data, inverted for odd parity.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int nbits,
                                       input logic mode);
    logic p;
    p = mode;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_param_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLK_DIV system_clk cycles,
// realignable to a start edge via reload.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic system_clk,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Divider counter, restarted from zero on reload.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (reload) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver in the system_clk domain: synchroniser, majority
// vote, framing/parity/break checks, valid/ready holding register, idle timeout.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV      = 27,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_TIMEOUT = 32
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 idle_timeout,
  output logic                 busy
);

  localparam int SW         = $clog2(OVERSAMPLE);
  localparam int M          = OVERSAMPLE / 2;
  localparam int IDLE_TICKS = IDLE_TIMEOUT * OVERSAMPLE;
  localparam int IW         = $clog2(IDLE_TICKS + 1);

  localparam logic [SW-1:0] S_MID_LO  = SW'(M - 1);
  localparam logic [SW-1:0] S_MID     = SW'(M);
  localparam logic [SW-1:0] S_DEC     = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  logic                  sync1_r, rx_s_r, rx_d_r;
  logic [2:0]            state_r, state_nxt_s;
  logic [SW-1:0]         s_r;
  logic [3:0]            bit_cnt_r;
  logic                  samp_a_r, samp_b_r;
  logic [DATA_BITS-1:0]  shift_r;
  logic                  frame_flag_r, parity_flag_r, zero_r, done_r;
  logic [IW-1:0]         idle_cnt_r;
  logic                  armed_r;
  logic [DATA_BITS-1:0]  rx_data_r;
  logic                  rx_valid_r, frame_err_r, parity_err_r, break_det_r;
  logic                  overrun_err_r, idle_timeout_r, busy_r;

  logic                  tick_s, fall_s, start_s, bit_end_s, dec_s, maj_s;
  logic                  finish_s, accept_s, parity_exp_s;
  logic [MAX_DATA_BITS-1:0] par_data_s;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .system_clk (system_clk),
    .reset      (reset),
    .reload     (start_s),
    .tick       (tick_s)
  );

  assign fall_s    = rx_d_r & ~rx_s_r;
  assign start_s   = (state_r == ST_IDLE) & fall_s;
  assign bit_end_s = tick_s & (s_r == S_LAST);
  assign dec_s     = tick_s & (s_r == S_DEC);
  assign maj_s     = (samp_a_r & samp_b_r) | (samp_a_r & rx_s_r) | (samp_b_r & rx_s_r);
  assign finish_s  = (state_r == ST_STOP) & dec_s & (bit_cnt_r == STOP_LAST);
  assign accept_s  = rx_valid_r & rx_ready;

  // Zero-extend the received word for the shared parity helper.
  always_comb begin
    par_data_s = '0;
    par_data_s[DATA_BITS-1:0] = shift_r;
    parity_exp_s = calc_parity(par_data_s, DATA_BITS, PAR_MODE);
  end

  // Two-flop synchroniser plus delayed copy for start-edge detection.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      rx_s_r  <= 1'b1;
      rx_d_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s_r  <= sync1_r;
      rx_d_r  <= rx_s_r;
    end
  end

  // Next-state logic; a frame completes at the last stop bit's decision point.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (dec_s && maj_s)  state_nxt_s = ST_IDLE;
        else if (bit_end_s)  state_nxt_s = ST_DATA;
        else                 state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == DATA_LAST))
          state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        else
          state_nxt_s = ST_DATA;
      end
      ST_PARITY: begin
        if (bit_end_s) state_nxt_s = ST_STOP;
        else           state_nxt_s = ST_PARITY;
      end
      ST_STOP: begin
        if (finish_s) state_nxt_s = maj_s ? ST_IDLE : ST_WAIT_HIGH;
        else          state_nxt_s = ST_STOP;
      end
      ST_WAIT_HIGH: begin
        if (rx_s_r) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_WAIT_HIGH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with busy registered from the next state.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Sample-position and bit counters.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      s_r       <= '0;
      bit_cnt_r <= 4'd0;
    end else begin
      if ((state_r == ST_IDLE) || (state_r == ST_WAIT_HIGH)) s_r <= '0;
      else if (tick_s) s_r <= (s_r == S_LAST) ? '0 : s_r + SW'(1);
      else s_r <= s_r;

      if (state_nxt_s != state_r) bit_cnt_r <= 4'd0;
      else if (bit_end_s)         bit_cnt_r <= bit_cnt_r + 4'd1;
      else                        bit_cnt_r <= bit_cnt_r;
    end
  end

  // Majority samples, data shift and per-frame flag staging.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      samp_a_r      <= 1'b1;
      samp_b_r      <= 1'b1;
      shift_r       <= '0;
      frame_flag_r  <= 1'b0;
      parity_flag_r <= 1'b0;
      zero_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      if (tick_s && (s_r == S_MID_LO)) samp_a_r <= rx_s_r;
      else                             samp_a_r <= samp_a_r;
      if (tick_s && (s_r == S_MID))    samp_b_r <= rx_s_r;
      else                             samp_b_r <= samp_b_r;

      if (start_s) begin
        frame_flag_r  <= 1'b0;
        parity_flag_r <= 1'b0;
        zero_r        <= 1'b1;
      end else if (dec_s) begin
        case (state_r)
          ST_DATA: begin
            shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
            zero_r  <= zero_r & ~maj_s;
          end
          ST_PARITY: begin
            parity_flag_r <= (maj_s != parity_exp_s);
            zero_r        <= zero_r & ~maj_s;
          end
          ST_STOP: begin
            frame_flag_r <= frame_flag_r | ~maj_s;
            zero_r       <= zero_r & ~maj_s;
          end
          default: zero_r <= zero_r;
        endcase
      end else begin
        zero_r <= zero_r;
      end

      done_r <= finish_s;
    end
  end

  // Holding register: a completing frame loads only if the slot is free or being drained.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      parity_err_r  <= 1'b0;
      break_det_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else if (done_r) begin
      if (!rx_valid_r || rx_ready) begin
        rx_data_r     <= shift_r;
        rx_valid_r    <= 1'b1;
        frame_err_r   <= frame_flag_r;
        parity_err_r  <= parity_flag_r;
        break_det_r   <= zero_r;
        overrun_err_r <= 1'b0;
      end else begin
        overrun_err_r <= 1'b1;
      end
    end else if (accept_s) begin
      rx_valid_r    <= 1'b0;
      frame_err_r   <= 1'b0;
      parity_err_r  <= 1'b0;
      break_det_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      rx_valid_r <= rx_valid_r;
    end
  end

  // Idle timeout: armed by a completed frame, fires once per gap.
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      armed_r        <= 1'b0;
      idle_cnt_r     <= '0;
      idle_timeout_r <= 1'b0;
    end else if (finish_s) begin
      armed_r        <= 1'b1;
      idle_cnt_r     <= '0;
      idle_timeout_r <= 1'b0;
    end else if (start_s) begin
      idle_cnt_r     <= '0;
      idle_timeout_r <= 1'b0;
    end else if (armed_r && (state_r == ST_IDLE) && tick_s) begin
      if (idle_cnt_r == IDLE_LAST) begin
        idle_timeout_r <= 1'b1;
        armed_r        <= 1'b0;
        idle_cnt_r     <= '0;
      end else begin
        idle_timeout_r <= 1'b0;
        idle_cnt_r     <= idle_cnt_r + IW'(1);
      end
    end else begin
      idle_timeout_r <= 1'b0;
    end
  end

  assign rx_data      = rx_data_r;
  assign rx_valid     = rx_valid_r;
  assign frame_err    = frame_err_r;
  assign parity_err   = parity_err_r;
  assign break_det    = break_det_r;
  assign overrun_err  = overrun_err_r;
  assign idle_timeout = idle_timeout_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomized bench for uart_rx_param; expected words come from
// a frame-level model (data bits, even parity by popcount, stop level).
module tb_uart_rx_param;

  localparam int BIT_CLKS = 32;

  logic       system_clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, break_det, overrun_err, idle_timeout, busy;

  always #5 system_clk = ~system_clk;

  uart_rx_param #(
    .CLK_DIV(2), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1), .IDLE_TIMEOUT(4)
  ) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .break_det  (break_det),
    .overrun_err(overrun_err),
    .idle_timeout(idle_timeout),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [10:0] cap_word [256];
  int cap_cyc [256];
  int wr_idx = 0;
  int rd_idx = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;

  always @(posedge system_clk) cyc <= cyc + 1;

  // Capture every accepted word and every idle_timeout pulse.
  always @(negedge system_clk) begin
    if (rx_valid && rx_ready) begin
      cap_word[wr_idx % 256] <= {frame_err, parity_err, break_det, rx_data};
      cap_cyc[wr_idx % 256]  <= cyc;
      wr_idx <= wr_idx + 1;
    end
    if (idle_timeout) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(st);
    drive_bit(1'b1);
  endtask

  // Pop one captured word (bounded wait), compare it, and require no extra words.
  task automatic check_word(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe, input logic be, output int c);
    int waited;
    logic [10:0] w;
    waited = 0;
    c = 0;
    while ((rd_idx == wr_idx) && (waited < 400)) begin
      step(1);
      waited++;
    end
    checks++;
    assert (rd_idx != wr_idx) else begin
      errors++;
      $error("FAIL %s_present: observed 0 words expected 1", tag);
    end
    if (rd_idx != wr_idx) begin
      w = cap_word[rd_idx % 256];
      c = cap_cyc[rd_idx % 256];
      rd_idx++;
      chk({tag, "_data"}, 32'(w[7:0]), 32'(d));
      chk({tag, "_frame_err"}, 32'(w[10]), 32'(fe));
      chk({tag, "_parity_err"}, 32'(w[9]), 32'(pe));
      chk({tag, "_break_det"}, 32'(w[8]), 32'(be));
      chk({tag, "_single_word"}, 32'(wr_idx - rd_idx), 32'd0);
    end
  endtask

  initial begin
    int c, base, dt, n;
    logic [7:0] d;
    logic p, st, pe, fe, be;

    // Reset state
    reset = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    step(4);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_break_det", 32'(break_det), 32'd0);
    chk("rst_overrun", 32'(overrun_err), 32'd0);
    chk("rst_idle_timeout", 32'(idle_timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    step(2 * BIT_CLKS);
    chk("no_timeout_after_reset", 32'(pulse_cnt), 32'd0);

    // Clean frame and idle timeout
    base = pulse_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    check_word("t1", 8'hA5, 1'b0, 1'b0, 1'b0, c);
    chk("t1_valid_dropped", 32'(rx_valid), 32'd0);
    step(300);
    chk("t1_one_pulse", 32'(pulse_cnt - base), 32'd1);
    dt = last_pulse_cyc - c;
    chk("t1_pulse_delay_near_128", 32'((dt >= 110) && (dt <= 140)), 32'd1);
    step(400);
    chk("t1_no_second_pulse", 32'(pulse_cnt - base), 32'd1);

    // Parity error
    send_frame(8'h3C, 1'b1, 1'b1);
    check_word("t2", 8'h3C, 1'b1, 1'b0, 1'b0, c);

    // Short glitch is a false start
    rx = 1'b0;
    step(8);
    rx = 1'b1;
    chk("t3_busy_seen", 32'(busy), 32'd1);
    n = 0;
    while (busy && (n < 20)) begin
      step(1);
      n++;
    end
    chk("t3_busy_cleared", 32'(busy), 32'd0);
    step(100);
    chk("t3_no_word", 32'(wr_idx - rd_idx), 32'd0);
    chk("t3_rx_valid", 32'(rx_valid), 32'd0);
    chk("t3_flags", 32'({frame_err, parity_err, break_det}), 32'd0);

    // Held break, then recovery
    rx = 1'b0;
    step(12 * BIT_CLKS);
    chk("t4_wait_high_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    step(10);
    chk("t4_idle_after_rise", 32'(busy), 32'd0);
    step(60);
    check_word("t4_break", 8'h00, 1'b0, 1'b1, 1'b1, c);
    send_frame(8'h81, even_par(8'h81), 1'b1);
    check_word("t4_after", 8'h81, 1'b0, 1'b0, 1'b0, c);

    // Overrun with stalled consumer
    rx_ready = 1'b0;
    send_frame(8'h11, even_par(8'h11), 1'b1);
    chk("t5_valid_first", 32'(rx_valid), 32'd1);
    chk("t5_data_first", 32'(rx_data), 32'h11);
    chk("t5_no_overrun_yet", 32'(overrun_err), 32'd0);
    send_frame(8'h22, even_par(8'h22), 1'b1);
    chk("t5_data_kept", 32'(rx_data), 32'h11);
    chk("t5_overrun", 32'(overrun_err), 32'd1);
    chk("t5_valid_kept", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("t5_valid_cleared", 32'(rx_valid), 32'd0);
    chk("t5_overrun_cleared", 32'(overrun_err), 32'd0);
    chk("t5_data_held", 32'(rx_data), 32'h11);
    rd_idx = wr_idx;
    rx_ready = 1'b1;

    // Reset during data bit 3
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx = d[3];
    step(16);
    reset = 1'b0;
    rx = 1'b1;
    step(1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rx_data", 32'(rx_data), 32'd0);
    chk("t6_rx_valid", 32'(rx_valid), 32'd0);
    chk("t6_flags", 32'({frame_err, parity_err, break_det, overrun_err, idle_timeout}), 32'd0);
    step(3);
    reset = 1'b1;
    step(2 * BIT_CLKS);
    chk("t6_no_word_from_aborted", 32'(wr_idx - rd_idx), 32'd0);
    send_frame(8'h5A, even_par(8'h5A), 1'b1);
    check_word("t6_after", 8'h5A, 1'b0, 1'b0, 1'b0, c);

    // Randomized frames against the frame-level model
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        d = 8'h00; p = 1'b0; st = 1'b0;
      end else begin
        d  = 8'($urandom_range(0, 255));
        p  = ($urandom_range(0, 1) == 1) ? even_par(d) : ~even_par(d);
        st = ($urandom_range(0, 3) != 0);
      end
      pe = (p != even_par(d));
      fe = ~st;
      be = (d == 8'h00) && !p && !st;
      send_frame(d, p, st);
      drive_bit(1'b1);
      check_word($sformatf("rand%0d", i), d, pe, fe, be, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
